seq_1011_gen: RTL

Serial pattern generator: the transmit end of the Moore 1011 sequence detector. On a start pulse it emits a parameterised bit pattern on a one-bit serial line a given number of times, MSB first, then a guard run of zeros. It drives the detector's serial input `a` in block-level benches and in system loopback, with one bit per `clk` cycle.

---
 rtl/seq_gen_pkg.sv | 22 ++
 rtl/seq_gen_bitidx.sv | 95 +++++++++
 rtl/seq_1011_gen.sv | 118 +++++++++++
 3 files changed

// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared types and defaults for the serial pattern generator.
//   state_e  - generator FSM states (idle, send, guard, done)
//   Def*     - default pattern, widths and guard length
//   send_len - cycles spent in SEND for a given repetition count; ovl_len is
//              the number of bits shared between repetitions (0 = no overlap)
package seq_gen_pkg;

  typedef enum logic [1:0] {StIdle, StSend, StGuard, StDone} state_e;

  localparam int unsigned DefPatW              = 4;
  localparam logic [DefPatW-1:0] DefPattern    = 4'b1011;
  localparam int unsigned DefOvlLen            = 1;
  localparam int unsigned DefRepW              = 4;
  localparam int unsigned DefGuardLen          = 2;

  function automatic int unsigned send_len(input int unsigned rep, input int unsigned pat_w,
                                           input int unsigned ovl_len);
    if (rep == 0) return 0;
    return pat_w + (rep - 1) * (pat_w - ovl_len);
  endfunction

endpackage

// File: rtl/seq_gen_bitidx.sv
// seq_gen_bitidx: bit-index / repetition down-counter pair for seq_1011_gen.
// Configuration macro: SEQ_GEN_OVERLAP_EN (when defined, later repetitions
// reuse the last OVL_LEN bits of the previous one).
// Ports:
//   clk_i   - clock, rising edge
//   res_i   - synchronous active-high reset, clears idx and rem
//   load_i  - accept a new frame: rem <= rep_i, idx <= PAT_W-1
//   step_i  - advance one bit (high while the FSM is in SEND)
//   rep_i   - repetition count to latch on load_i
//   idx_o   - current pattern bit index
//   last_o  - current bit is the final bit of the final repetition
module seq_gen_bitidx
  import seq_gen_pkg::*;
#(
  parameter int unsigned PAT_W   = DefPatW,
  parameter int unsigned OVL_LEN = DefOvlLen,
  parameter int unsigned REP_W   = DefRepW
) (
  input  logic                     clk_i,
  input  logic                     res_i,
  input  logic                     load_i,
  input  logic                     step_i,
  input  logic [REP_W-1:0]         rep_i,
  output logic [$clog2(PAT_W)-1:0] idx_o,
  output logic                     last_o
);

  localparam int unsigned IdxW = $clog2(PAT_W);

`ifdef SEQ_GEN_OVERLAP_EN
  localparam int unsigned EffOvl = OVL_LEN;
`else
  // Without overlap every repetition is sent in full; OVL_LEN has no effect.
  localparam int unsigned EffOvl = 0 * OVL_LEN;
`endif

  localparam logic [IdxW-1:0] FirstIdx  = IdxW'(PAT_W - 1);
  localparam logic [IdxW-1:0] ReloadIdx = IdxW'(PAT_W - 1 - EffOvl);

  logic [IdxW-1:0]  idx_q, idx_d;
  logic [REP_W-1:0] rem_q, rem_d;

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      idx_q <= '0;
      rem_q <= '0;
    end else begin
      idx_q <= idx_d;
      rem_q <= rem_d;
    end
  end

  always_comb begin
    idx_d = idx_q;
    rem_d = rem_q;
    if (load_i) begin
      rem_d = rep_i;
      idx_d = FirstIdx;
    end else if (step_i) begin
      if (idx_q != '0) begin
        idx_d = idx_q - IdxW'(1);
      end else if (rem_q > REP_W'(1)) begin
        rem_d = rem_q - REP_W'(1);
        idx_d = ReloadIdx;
      end else begin
        rem_d = '0;
      end
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == '0) && (rem_q == REP_W'(1));

`ifndef SYNTHESIS
  // Frame-length cross-check: SEND must last exactly send_len() cycles.
  logic [REP_W-1:0] chk_rep_q;
  int unsigned      chk_cnt_q;

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      chk_rep_q <= '0;
      chk_cnt_q <= 0;
    end else if (load_i) begin
      chk_rep_q <= rep_i;
      chk_cnt_q <= 0;
    end else if (step_i) begin
      chk_cnt_q <= chk_cnt_q + 1;
      if (last_o) begin
        assert (chk_cnt_q + 1 == send_len(32'(chk_rep_q), PAT_W, EffOvl));
      end
    end
  end
`endif

endmodule

// File: rtl/seq_1011_gen.sv
// seq_1011_gen: serial pattern generator feeding the Moore 1011 detector.
// On an accepted start it sends PATTERN (MSB first) rep times on `a`, then
// GUARD_LEN zero bits, then pulses `done` for one cycle.
// Configuration macro: SEQ_GEN_OVERLAP_EN (handled in seq_gen_bitidx).
// Ports:
//   clk   - clock, rising edge
//   res   - synchronous active-high reset; abandons any frame, no done
//   start - request pulse, sampled only in IDLE
//   rep   - repetition count, latched with an accepted start (0 = ignored)
//   a     - serial data bit
//   valid - a carries a pattern bit
//   busy  - high in SEND and GUARD
//   done  - one-cycle pulse after GUARD
module seq_1011_gen
  import seq_gen_pkg::*;
#(
  parameter int unsigned      PAT_W     = DefPatW,
  parameter logic [PAT_W-1:0] PATTERN   = DefPattern,
  parameter int unsigned      OVL_LEN   = DefOvlLen,
  parameter int unsigned      REP_W     = DefRepW,
  parameter int unsigned      GUARD_LEN = DefGuardLen
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic [REP_W-1:0] rep,
  output logic             a,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IdxW  = $clog2(PAT_W);
  localparam int unsigned GcntW = $clog2(GUARD_LEN + 1);

  state_e             state_q, state_d;
  logic [GcntW-1:0]   gcnt_q, gcnt_d;
  logic [IdxW-1:0]    idx;
  logic               last;
  logic               accept;
  logic               in_send;

  assign accept  = (state_q == StIdle) && start && (rep != '0);
  assign in_send = (state_q == StSend);

  seq_gen_bitidx #(
    .PAT_W  (PAT_W),
    .OVL_LEN(OVL_LEN),
    .REP_W  (REP_W)
  ) u_bitidx (
    .clk_i (clk),
    .res_i (res),
    .load_i(accept),
    .step_i(in_send),
    .rep_i (rep),
    .idx_o (idx),
    .last_o(last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= StIdle;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StSend;
      end
      StSend: begin
        if (last) begin
          state_d = StGuard;
          gcnt_d  = GcntW'(GUARD_LEN - 1);
        end
      end
      StGuard: begin
        if (gcnt_q == '0) begin
          state_d = StDone;
        end else begin
          gcnt_d = gcnt_q - GcntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from registered state only
  always_comb begin
    a     = 1'b0;
    valid = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      StIdle: ;
      StSend: begin
        a     = PATTERN[idx];
        valid = 1'b1;
        busy  = 1'b1;
      end
      StGuard: busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
